// File: rtl/bram_loader.sv
// ============================================================================
// Module   : bram_loader
// Packs a byte stream little-endian into words and writes them to a BRAM.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bram_loader #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DEPTH          = 256,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  i_clk_wr,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [ADDR_WIDTH:0]   i_num_words,
    input  logic                  i_byte_valid,
    input  logic [7:0]            i_byte,
    output logic                  o_byte_ready,
    output logic                  o_wr_en,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_timeout,
    output logic                  o_err,
    output logic [ADDR_WIDTH:0]   o_words_written
);

    localparam int BPW = DATA_WIDTH / 8;
    localparam int BIW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int TW  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [BIW-1:0]        LAST_BYTE = BIW'(BPW - 1);
    localparam logic [TW-1:0]         TO_LIMIT  = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BIW-1:0]        byte_idx_q, byte_idx_d;
    logic [DATA_WIDTH-1:0] word_buf_q, word_buf_d;
    logic [TW-1:0]         idle_q, idle_d;
    logic [ADDR_WIDTH:0]   words_q, words_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  timeout_q, timeout_d;
    logic                  err_q, err_d;
    logic                  accept;

    assign accept = i_byte_valid & ready_q;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        addr_d     = addr_q;
        byte_idx_d = byte_idx_q;
        word_buf_d = word_buf_q;
        idle_d     = idle_q;
        words_d    = words_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        ready_d    = ready_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        timeout_d  = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                ready_d = 1'b0;
                busy_d  = 1'b0;
                if (i_start) begin
                    if (({1'b0, i_base_addr} >= DEPTH_W) || (i_num_words > DEPTH_W)) begin
                        err_d = 1'b1;
                    end else if (i_num_words == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        words_d = '0;
                    end else begin
                        state_d    = S_LOAD;
                        count_d    = i_num_words;
                        addr_d     = i_base_addr;
                        byte_idx_d = '0;
                        words_d    = '0;
                        idle_d     = '0;
                        ready_d    = 1'b1;
                        busy_d     = 1'b1;
                    end
                end
            end

            S_LOAD: begin
                if (accept) begin
                    for (int k = 0; k < BPW; k++) begin
                        if (byte_idx_q == BIW'(k)) begin
                            word_buf_d[8*k +: 8] = i_byte;
                        end
                    end
                    idle_d = '0;
                    if (byte_idx_q == LAST_BYTE) begin
                        state_d   = S_WRITE;
                        ready_d   = 1'b0;
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = word_buf_d;
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                    end
                end else if (TIMEOUT_CYCLES != 0) begin
                    // Partial word is dropped; words_q already counts only full words.
                    if (idle_q == TO_LIMIT) begin
                        state_d   = S_IDLE;
                        timeout_d = 1'b1;
                        ready_d   = 1'b0;
                        busy_d    = 1'b0;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
            end

            S_WRITE: begin
                words_d    = words_q + 1'b1;
                addr_d     = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
                byte_idx_d = '0;
                if (words_d == count_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d = S_LOAD;
                    ready_d = 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk_wr) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            addr_q     <= '0;
            byte_idx_q <= '0;
            word_buf_q <= '0;
            idle_q     <= '0;
            words_q    <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            addr_q     <= addr_d;
            byte_idx_q <= byte_idx_d;
            word_buf_q <= word_buf_d;
            idle_q     <= idle_d;
            words_q    <= words_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            err_q      <= err_d;
        end
    end

    assign o_byte_ready    = ready_q;
    assign o_wr_en         = wr_en_q;
    assign o_wr_addr       = wr_addr_q;
    assign o_wr_data       = wr_data_q;
    assign o_busy          = busy_q;
    assign o_done          = done_q;
    assign o_timeout       = timeout_q;
    assign o_err           = err_q;
    assign o_words_written = words_q;

endmodule

`default_nettype wire
